// File: rtl/cp0_int_ctrl_pkg.sv
// Shared CP0 definitions: register numbers, SR/Cause field positions and
// the EXL-driven run/handler state encoding.
package cp0_int_ctrl_pkg;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam int IM_HI  = 15;
  localparam int IM_LO  = 10;
  localparam int SR_EXL = 1;
  localparam int SR_IE  = 0;

  localparam int HWINT_TIMER0 = 0;
  localparam int HWINT_TIMER1 = 1;

  // EXL is the state bit itself, so the encoding must stay 0=RUN, 1=HANDLER
  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_HANDLER = 1'b1
  } cp0_state_e;

  function automatic logic [31:0] pack_sr(input logic [5:0] im,
                                          input logic exl,
                                          input logic ie);
    return {16'h0000, im, 8'h00, exl, ie};
  endfunction

  function automatic logic [31:0] pack_cause(input logic [5:0] ip);
    return {16'h0000, ip, 10'h000};
  endfunction

endpackage

// File: rtl/cp0_int_ctrl.sv
// Coprocessor-0 interrupt controller: SR/Cause/EPC/PrID, HWInt sampling into
// Cause.IP and the IntReq line to the pipeline controller.
module cp0_int_ctrl
  import cp0_int_ctrl_pkg::*;
#(
  parameter logic [31:0] PRID_VAL = 32'h0000_2015,
  parameter logic [29:0] EPC_RST  = 30'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  addr,
  input  logic        we,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  input  logic [5:0]  HWInt,
  input  logic [29:0] PC,
  input  logic        EXLSet,
  input  logic        EXLClr,
  output logic        IntReq,
  output logic [29:0] EPC
);

  cp0_state_e  state_r;
  cp0_state_e  state_nxt_s;
  logic [5:0]  im_r;
  logic        ie_r;
  logic [5:0]  ip_r;
  logic [29:0] epc_r;
  logic        sr_wr_s;
  logic        epc_wr_s;
  logic        exl_s;

  assign sr_wr_s  = we && (addr == REG_SR);
  assign epc_wr_s = we && (addr == REG_EPC);
  assign exl_s    = (state_r == ST_HANDLER);

  // State register: the EXL bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state: EXLSet beats EXLClr beats an SR write
  always_comb begin
    state_nxt_s = state_r;
    if (EXLSet) begin
      state_nxt_s = ST_HANDLER;
    end else if (EXLClr) begin
      state_nxt_s = ST_RUN;
    end else if (sr_wr_s) begin
      state_nxt_s = Din[SR_EXL] ? ST_HANDLER : ST_RUN;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Mask, enable, pending sampler and EPC; EPC captured only on entry from RUN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im_r  <= 6'h00;
      ie_r  <= 1'b0;
      ip_r  <= 6'h00;
      epc_r <= EPC_RST;
    end else begin
      ip_r <= HWInt;
      if (sr_wr_s) begin
        im_r <= Din[IM_HI:IM_LO];
        ie_r <= Din[SR_IE];
      end else begin
        im_r <= im_r;
        ie_r <= ie_r;
      end
      if (EXLSet && (state_r == ST_RUN)) begin
        epc_r <= PC;
      end else if (EXLSet) begin
        epc_r <= epc_r;
      end else if (epc_wr_s) begin
        epc_r <= Din[31:2];
      end else begin
        epc_r <= epc_r;
      end
    end
  end

  // Outputs: interrupt request and mfc0 read mux, both from registered state
  always_comb begin
    IntReq = (|(ip_r & im_r)) & ie_r & ~exl_s;
    EPC    = epc_r;
    Dout   = 32'h0000_0000;
    case (addr)
      REG_SR:    Dout = pack_sr(im_r, exl_s, ie_r);
      REG_CAUSE: Dout = pack_cause(ip_r);
      REG_EPC:   Dout = {epc_r, 2'b00};
      REG_PRID:  Dout = PRID_VAL;
      default:   Dout = 32'h0000_0000;
    endcase
  end

endmodule

// File: tb/tb_cp0_int_ctrl.sv
// Directed scoreboard bench for cp0_int_ctrl: expectations are queued as
// stimulus is applied and drained against the DUT between clock edges.
`timescale 1ns/1ps
module tb_cp0_int_ctrl;

  localparam int K_DOUT = 0;
  localparam int K_IRQ  = 1;
  localparam int K_EPC  = 2;

  typedef struct {
    string       tag;
    int          kind;
    logic [4:0]  a;
    logic [31:0] v;
  } sb_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  addr;
  logic        we;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic [5:0]  HWInt;
  logic [29:0] PC;
  logic        EXLSet;
  logic        EXLClr;
  logic        IntReq;
  logic [29:0] EPC;

  sb_t sb[$];
  int  checks = 0;
  int  errors = 0;

  cp0_int_ctrl #(.PRID_VAL(32'h0000_2015), .EPC_RST(30'h0)) dut (
    .clk(clk), .reset(reset), .addr(addr), .we(we), .Din(Din), .Dout(Dout),
    .HWInt(HWInt), .PC(PC), .EXLSet(EXLSet), .EXLClr(EXLClr),
    .IntReq(IntReq), .EPC(EPC)
  );

  always #50 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input int kind, input logic [4:0] a, input logic [31:0] v);
    sb_t e;
    e.tag = tag; e.kind = kind; e.a = a; e.v = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    sb_t         e;
    logic [4:0]  saved;
    logic [31:0] obs;
    saved = addr;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.kind == K_DOUT) addr = e.a;
      #1;
      if (e.kind == K_DOUT)     obs = Dout;
      else if (e.kind == K_IRQ) obs = {31'h0, IntReq};
      else                      obs = {2'b00, EPC};
      checks++;
      assert (obs === e.v) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.v);
      end
    end
    addr = saved;
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; Din = d;
  endtask

  task automatic idle_bus();
    we = 1'b0; addr = 5'd0; Din = 32'h0; EXLSet = 1'b0; EXLClr = 1'b0;
  endtask

  initial begin
    reset = 1'b0; idle_bus(); HWInt = 6'h00; PC = 30'h0;
    #1;
    push("rst_irq", K_IRQ, 5'd0, 32'h0);
    push("rst_sr", K_DOUT, 5'd12, 32'h0);
    push("rst_cause", K_DOUT, 5'd13, 32'h0);
    push("rst_epc", K_DOUT, 5'd14, 32'h0);
    push("rst_prid", K_DOUT, 5'd15, 32'h0000_2015);
    drain();
    cyc(); cyc();
    reset = 1'b1;
    cyc();

    // Basic entry
    mtc0(5'd12, 32'h0000_0401);
    push("rdw_old_sr", K_DOUT, 5'd12, 32'h0);
    drain();
    cyc();
    idle_bus();
    push("sr_written", K_DOUT, 5'd12, 32'h0000_0401);
    drain();
    HWInt = 6'b000001;
    push("irq_before_sync", K_IRQ, 5'd0, 32'h0);
    drain();
    cyc();
    push("irq_after_sync", K_IRQ, 5'd0, 32'h1);
    push("cause_ip0", K_DOUT, 5'd13, 32'h0000_0400);
    drain();
    EXLSet = 1'b1; PC = 30'h0000_0C01;
    cyc();
    idle_bus();
    push("entry_irq_drop", K_IRQ, 5'd0, 32'h0);
    push("entry_epc_reg", K_DOUT, 5'd14, 32'h0000_3004);
    push("entry_sr_exl", K_DOUT, 5'd12, 32'h0000_0403);
    push("entry_epc_port", K_EPC, 5'd0, 32'h0000_0C01);
    drain();

    // eret with source still asserted
    EXLClr = 1'b1;
    cyc();
    idle_bus();
    push("eret_sr", K_DOUT, 5'd12, 32'h0000_0401);
    push("eret_irq_back", K_IRQ, 5'd0, 32'h1);
    drain();
    HWInt = 6'b000000;
    push("drop_irq_still", K_IRQ, 5'd0, 32'h1);
    drain();
    cyc();
    push("drop_irq_gone", K_IRQ, 5'd0, 32'h0);
    push("drop_cause", K_DOUT, 5'd13, 32'h0);
    drain();

    // Masking
    HWInt = 6'b000010;
    cyc();
    push("mask_irq_off", K_IRQ, 5'd0, 32'h0);
    push("mask_cause", K_DOUT, 5'd13, 32'h0000_0800);
    drain();
    mtc0(5'd12, 32'h0000_0C01);
    cyc();
    idle_bus();
    push("unmask_irq", K_IRQ, 5'd0, 32'h1);
    push("unmask_sr", K_DOUT, 5'd12, 32'h0000_0C01);
    drain();
    mtc0(5'd12, 32'h0000_0001);
    cyc();
    idle_bus();
    push("remask_irq", K_IRQ, 5'd0, 32'h0);
    push("remask_ip", K_DOUT, 5'd13, 32'h0000_0800);
    drain();

    // Collisions
    mtc0(5'd12, 32'h0000_0C01);
    cyc();
    mtc0(5'd12, 32'h0000_0000); EXLSet = 1'b1; PC = 30'h0000_0123;
    cyc();
    idle_bus();
    push("col_sr", K_DOUT, 5'd12, 32'h0000_0002);
    push("col_epc", K_EPC, 5'd0, 32'h0000_0123);
    push("col_irq", K_IRQ, 5'd0, 32'h0);
    drain();
    mtc0(5'd12, 32'h0000_0000);
    cyc();
    mtc0(5'd14, 32'hFFFF_FFFC); EXLSet = 1'b1; PC = 30'h0000_02AB;
    cyc();
    idle_bus();
    push("col_epc_vs_mtc0", K_EPC, 5'd0, 32'h0000_02AB);
    push("col_epc_reg", K_DOUT, 5'd14, 32'h0000_0AAC);
    push("col_sr_exl", K_DOUT, 5'd12, 32'h0000_0002);
    drain();
    EXLSet = 1'b1; PC = 30'h0000_03FF;
    cyc();
    idle_bus();
    push("nested_epc_kept", K_EPC, 5'd0, 32'h0000_02AB);
    drain();
    EXLClr = 1'b1;
    cyc();
    idle_bus();
    push("clr_sr", K_DOUT, 5'd12, 32'h0);
    drain();
    EXLSet = 1'b1; EXLClr = 1'b1; PC = 30'h0000_0010;
    cyc();
    idle_bus();
    push("set_beats_clr", K_DOUT, 5'd12, 32'h0000_0002);
    drain();
    mtc0(5'd14, 32'h0000_1000);
    cyc();
    idle_bus();
    push("mtc0_epc", K_DOUT, 5'd14, 32'h0000_1000);
    drain();
    mtc0(5'd12, 32'h0000_0002); EXLClr = 1'b1;
    cyc();
    idle_bus();
    push("clr_beats_mtc0", K_DOUT, 5'd12, 32'h0);
    drain();

    // Read-only and unmapped registers
    mtc0(5'd13, 32'hFFFF_FFFF);
    cyc();
    mtc0(5'd15, 32'h0000_0000);
    cyc();
    mtc0(5'd5, 32'hFFFF_FFFF);
    cyc();
    idle_bus();
    push("ro_cause", K_DOUT, 5'd13, 32'h0000_0800);
    push("ro_prid", K_DOUT, 5'd15, 32'h0000_2015);
    push("unmapped_rd", K_DOUT, 5'd5, 32'h0);
    push("unmapped_sr", K_DOUT, 5'd12, 32'h0);
    push("unmapped_epc", K_DOUT, 5'd14, 32'h0000_1000);
    drain();

    // Reset in the middle of a handler
    mtc0(5'd12, 32'h0000_FC01); HWInt = 6'h3F;
    cyc();
    idle_bus();
    cyc();
    push("pre_rst_irq", K_IRQ, 5'd0, 32'h1);
    drain();
    EXLSet = 1'b1; PC = 30'h0000_0555;
    cyc();
    idle_bus();
    push("pre_rst_sr", K_DOUT, 5'd12, 32'h0000_FC03);
    drain();
    reset = 1'b0;
    push("mid_rst_irq", K_IRQ, 5'd0, 32'h0);
    push("mid_rst_sr", K_DOUT, 5'd12, 32'h0);
    push("mid_rst_epc", K_DOUT, 5'd14, 32'h0);
    push("mid_rst_cause", K_DOUT, 5'd13, 32'h0);
    push("mid_rst_prid", K_DOUT, 5'd15, 32'h0000_2015);
    drain();
    cyc();
    reset = 1'b1;
    cyc(); cyc();
    push("post_rst_ip", K_DOUT, 5'd13, 32'h0000_FC00);
    push("post_rst_irq", K_IRQ, 5'd0, 32'h0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
